// File: rtl/vend_change_controller.sv
// Vending purchase/refund sequencer: accepts buy or cancel against the coin
// total, then pays change one coin at a time with a fixed pulse spacing.
module vend_change_controller #(
  parameter int PRICE0      = 35,
  parameter int PRICE1      = 50,
  parameter int PRICE2      = 65,
  parameter int PRICE3      = 75,
  parameter int DISP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] total,
  input  logic [1:0] sel,
  input  logic       buy,
  input  logic       cancel,
  output logic       coin_clear,
  output logic       vend,
  output logic       insufficient,
  output logic       dispense_25,
  output logic       dispense_10,
  output logic       dispense_5,
  output logic       busy,
  output logic [6:0] change_owed
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEND   = 3'd1,
    REFUND = 3'd2,
    PAY    = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam logic [6:0] PRICE_0 = 7'(PRICE0);
  localparam logic [6:0] PRICE_1 = 7'(PRICE1);
  localparam logic [6:0] PRICE_2 = 7'(PRICE2);
  localparam logic [6:0] PRICE_3 = 7'(PRICE3);
  // GAP is held for DISP_CYCLES-1 cycles; the counter runs down to zero.
  localparam logic [3:0] GAP_LOAD = (DISP_CYCLES > 1) ? 4'(DISP_CYCLES - 2) : 4'd0;

  state_t     state;
  logic [3:0] gap_cnt;
  logic [6:0] price;
  logic [6:0] pay_next;

  function automatic logic [2:0] coin_sel(input logic [6:0] owed);
    if (owed >= 7'd25)      return 3'b100;
    else if (owed >= 7'd10) return 3'b010;
    else                    return 3'b001;
  endfunction

  function automatic logic [6:0] coin_val(input logic [6:0] owed);
    if (owed >= 7'd25)      return 7'd25;
    else if (owed >= 7'd10) return 7'd10;
    else                    return 7'd5;
  endfunction

  always_comb begin
    price = PRICE_0;
    case (sel)
      2'd0:    price = PRICE_0;
      2'd1:    price = PRICE_1;
      2'd2:    price = PRICE_2;
      default: price = PRICE_3;
    endcase
  end

  assign pay_next = change_owed - coin_val(change_owed);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      gap_cnt      <= 4'd0;
      change_owed  <= 7'd0;
      coin_clear   <= 1'b0;
      vend         <= 1'b0;
      insufficient <= 1'b0;
      dispense_25  <= 1'b0;
      dispense_10  <= 1'b0;
      dispense_5   <= 1'b0;
    end else begin
      coin_clear   <= 1'b0;
      vend         <= 1'b0;
      insufficient <= 1'b0;
      {dispense_25, dispense_10, dispense_5} <= 3'b000;
      case (state)
        IDLE: begin
          if (buy) begin
            if (total >= price) begin
              state       <= VEND;
              vend        <= 1'b1;
              coin_clear  <= 1'b1;
              change_owed <= total - price;
            end else begin
              insufficient <= 1'b1;
            end
          end else if (cancel && (total != 7'd0)) begin
            state       <= REFUND;
            coin_clear  <= 1'b1;
            change_owed <= total;
          end
        end
        VEND, REFUND: begin
          if (change_owed >= 7'd5) begin
            state <= PAY;
            {dispense_25, dispense_10, dispense_5} <= coin_sel(change_owed);
          end else begin
            state       <= IDLE;
            change_owed <= 7'd0;
          end
        end
        PAY: begin
          change_owed <= pay_next;
          if (DISP_CYCLES > 1) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else if (pay_next >= 7'd5) begin
            {dispense_25, dispense_10, dispense_5} <= coin_sel(pay_next);
          end else begin
            state       <= IDLE;
            change_owed <= 7'd0;
          end
        end
        GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (change_owed >= 7'd5) begin
            state <= PAY;
            {dispense_25, dispense_10, dispense_5} <= coin_sel(change_owed);
          end else begin
            // sub-nickel residue is forfeited
            state       <= IDLE;
            change_owed <= 7'd0;
          end
        end
        default: begin
          state       <= IDLE;
          change_owed <= 7'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/vend_change_controller.md
VEND_CHANGE_CONTROLLER -- requirements
Module: vend_change_controller

Interface
REQ-001 SHALL have parameter PRICE0, default 35, price of item 0 in cents (legal 1..127).
REQ-002 SHALL have parameter PRICE1, default 50, price of item 1 in cents (legal 1..127).
REQ-003 SHALL have parameter PRICE2, default 65, price of item 2 in cents (legal 1..127).
REQ-004 SHALL have parameter PRICE3, default 75, price of item 3 in cents (legal 1..127).
REQ-005 SHALL have parameter DISP_CYCLES, default 4, start-to-start spacing of change pulses in cycles (legal 1..15).
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port total  input  7  current credit in cents from the coin accumulator.
REQ-009 SHALL have port sel  input  2  item index for buy.
REQ-010 SHALL have port buy  input  1  purchase request, sampled each edge.
REQ-011 SHALL have port cancel  input  1  refund request, sampled each edge.
REQ-012 SHALL have port coin_clear  output  1  one-cycle pulse that clears the accumulator.
REQ-013 SHALL have port vend  output  1  one-cycle item-release pulse.
REQ-014 SHALL have port insufficient  output  1  one-cycle pulse: credit below price.
REQ-015 SHALL have port dispense_25, dispense_10, dispense_5  output  1 each  one-cycle change-coin pulses.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port change_owed  output  7  change still to be paid, in cents.

Function
REQ-018 SHALL implement states IDLE, VEND, REFUND, PAY, GAP; all outputs SHALL be registered or decoded from registered state only.
REQ-019 In IDLE, buy at edge N with total >= PRICE[sel] SHALL load change_owed = total - PRICE[sel] and enter VEND; vend and coin_clear high during cycle N+1 only.
REQ-020 In IDLE, buy at edge N with total < PRICE[sel] SHALL stay in IDLE and pulse insufficient during cycle N+1; no coin_clear, no vend.
REQ-021 In IDLE, cancel (without buy) at edge N with total > 0 SHALL load change_owed = total and enter REFUND; coin_clear high during cycle N+1, vend low.
REQ-022 Cancel with total == 0 SHALL be ignored; buy and cancel together SHALL be treated as buy only.
REQ-023 Total SHALL be used only as sampled at the accepting edge; later changes to total SHALL not affect change_owed.
REQ-024 From VEND or REFUND: change_owed >= 5 -> PAY, else -> IDLE.
REQ-025 In PAY exactly one dispense pulse SHALL be high, chosen greedily: >=25 -> dispense_25, else >=10 -> dispense_10, else dispense_5; change_owed SHALL decrease by that amount at the PAY exit edge.
REQ-026 After PAY: GAP for DISP_CYCLES-1 cycles (skipped if DISP_CYCLES==1), then PAY if change_owed >= 5, else IDLE.
REQ-027 A residue of 1..4 cents left when returning to IDLE SHALL be forfeited; change_owed SHALL be 0 in IDLE.
REQ-028 buy and cancel SHALL be ignored whenever busy is high; no request is queued.
REQ-029 Subtraction SHALL be 7-bit unsigned and can never underflow because of REQ-019's compare.

Reset
REQ-030 reset SHALL asynchronously force IDLE, change_owed = 0 and all pulse outputs and busy low, including mid-VEND/PAY/GAP; pending change SHALL be discarded.
REQ-031 After reset deassertion the first edge SHALL accept buy/cancel normally.

Verification
REQ-032 total=50, sel=0, buy -> vend+coin_clear at N+1; dispense_10 then dispense_5 four cycles apart; busy low after last GAP.
REQ-033 total=30, sel=0, buy -> insufficient at N+1 only; no vend, coin_clear or dispense; busy stays low.
REQ-034 total=40, cancel -> coin_clear without vend; dispense_25, _10, _5 at 4-cycle spacing; change_owed 40->15->5->0.
REQ-035 total=75, sel=3, buy -> vend for one cycle, busy high one cycle, no dispense; buy during busy ignored.
REQ-036 total=127, sel=3, buy -> change_owed 52; two dispense_25 pulses; 2 cents forfeited; change_owed 0 in IDLE.
REQ-037 reset asserted during first GAP of REQ-032 -> all outputs low immediately; no further dispense after release.
